// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: row sweep, 2-FF column synchronizer, press/release
// debounce, and a one-cycle key_valid strobe carrying the row*4+col code.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_sweep,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 32'sd1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
  localparam logic SINGLE_TICK = (DEBOUNCE_CNT == 32'sd1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       col_meta_r;
  logic [3:0]       col_s_r;
  logic [1:0]       row_idx_r;
  logic [1:0]       col_idx_r;
  logic [3:0]       row_sweep_r;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  logic             key_held_r;

  logic             tick_s;
  logic             col_valid_s;
  logic             col_same_s;
  logic             col_hit_s;
  logic [1:0]       col_idx_s;
  logic [1:0]       row_idx_s;
  logic [3:0]       col_hot_s;
  logic [CNT_W-1:0] cnt_inc_s;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  assign row_sweep = row_sweep_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

  // Tick, column qualification and saturating counter increment.
  always_comb begin
    tick_s      = (div_r == DIV_LAST);
    // Exactly one bit set; zero bits or ghosting both read as no key.
    col_valid_s = (col_s_r != 4'b0000) && ((col_s_r & (col_s_r - 4'b0001)) == 4'b0000);
    col_hot_s   = 4'b0001 << col_idx_r;
    col_same_s  = (col_s_r == col_hot_s);
    col_hit_s   = |(col_s_r & col_hot_s);
    col_idx_s   = onehot_idx(col_s_r);
    row_idx_s   = onehot_idx(row_sweep_r);
    if (cnt_r >= CNT_DONE) begin
      cnt_inc_s = CNT_DONE;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Free-running dwell divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(32'sd1);
    end
  end

  // Two-stage synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_r <= 4'b0000;
      col_s_r    <= 4'b0000;
    end else begin
      col_meta_r <= col_in;
      col_s_r    <= col_meta_r;
    end
  end

  // Scan/debounce FSM with registered outputs; acts only on sample ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_SCAN;
      cnt_r       <= '0;
      row_idx_r   <= 2'd0;
      col_idx_r   <= 2'd0;
      row_sweep_r <= 4'b0001;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_SCAN: begin
            if (col_valid_s) begin
              row_idx_r <= row_idx_s;
              col_idx_r <= col_idx_s;
              cnt_r     <= CNT_ONE;
              if (SINGLE_TICK) begin
                key_code_r  <= {row_idx_s, col_idx_s};
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                state_r     <= ST_PRESSED;
              end else begin
                state_r <= ST_DEBOUNCE;
              end
            end else begin
              row_sweep_r <= rotl(row_sweep_r);
            end
          end
          ST_DEBOUNCE: begin
            if (col_same_s) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == CNT_DONE) begin
                key_code_r  <= {row_idx_r, col_idx_r};
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                state_r     <= ST_PRESSED;
              end
            end else begin
              row_sweep_r <= rotl(row_sweep_r);
              state_r     <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            // Only the latched column matters here; extra bits are ignored.
            if (!col_hit_s) begin
              cnt_r <= CNT_ONE;
              if (SINGLE_TICK) begin
                key_held_r  <= 1'b0;
                row_sweep_r <= rotl(row_sweep_r);
                state_r     <= ST_SCAN;
              end else begin
                state_r <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (!col_hit_s) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == CNT_DONE) begin
                key_held_r  <= 1'b0;
                row_sweep_r <= rotl(row_sweep_r);
                state_r     <= ST_SCAN;
              end
            end else begin
              state_r <= ST_PRESSED;
            end
          end
          default: begin
            state_r <= ST_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce (SCAN_DIV=4, DEBOUNCE_CNT=3) using a
// small keypad model that closes one switch at a given row/column.
module tb_keypad_scan_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_sweep;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_sweep (row_sweep),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic       raw_on;
    logic [3:0] raw_col;
    logic       kp_on;
    logic [1:0] kp_row;
    logic [1:0] kp_col;
    int         cycles;
    int         exp_strobes;
    logic [3:0] exp_code;
    logic       exp_held;
    logic [3:0] exp_row;
  } phase_t;

  localparam int NPH = 18;
  phase_t     ph [NPH];
  logic [3:0] exp_rot [16];

  int         checks;
  int         failures;
  int         strobes;
  logic [3:0] last_code;
  logic       raw_on;
  logic [3:0] raw_col;
  logic       kp_on;
  logic [1:0] kp_row;
  logic [1:0] kp_col;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Keypad model: a closed switch shows on its column only while its row is driven.
  task automatic drive_cols();
    if (raw_on) begin
      col_in = raw_col;
    end else if (kp_on && row_sweep[kp_row]) begin
      col_in = 4'b0001 << kp_col;
    end else begin
      col_in = 4'b0000;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    drive_cols();
    if (key_valid === 1'b1) begin
      strobes++;
      last_code = key_code;
      chk("held_at_strobe", {3'b000, key_held}, 4'b0001);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_row", row_sweep, 4'b0001);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", {3'b000, key_valid}, 4'b0000);
    chk("rst_held", {3'b000, key_held}, 4'b0000);
    drive_cols();
    repeat (10) cyc();
    chk("rst_hold_row", row_sweep, 4'b0001);
    rst = 1'b1;
    drive_cols();
  endtask

  initial begin
    checks = 0; failures = 0; strobes = 0; last_code = 4'd0;
    raw_on = 1'b0; raw_col = 4'b0000; kp_on = 1'b0; kp_row = 2'd0; kp_col = 2'd0;
    rst = 1'b1; col_in = 4'b0000;

    //            rst   raw   rawcol  kp    row   col  cyc str code  held  row
    ph[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 2'd2, 60, 1, 4'd6,  1'b1, 4'b0010}; // clean press key 6
    ph[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 2'd2, 10, 0, 4'd6,  1'b1, 4'b0010}; // release, 2 ticks in
    ph[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 2'd2, 4,  0, 4'd6,  1'b0, 4'b0100}; // 3rd tick releases
    ph[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 2'd3, 2'd3, 12, 0, 4'd6,  1'b0, 4'b1000}; // key 15 debouncing
    ph[4]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd3, 2'd3, 23, 0, 4'd0,  1'b0, 4'b1000}; // reset mid-debounce
    ph[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 2'd3, 2'd3, 7,  1, 4'd15, 1'b1, 4'b1000};
    ph[6]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 4,  0, 4'd0,  1'b0, 4'b0001}; // press bounce
    ph[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 4,  0, 4'd0,  1'b0, 4'b0010};
    ph[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 4,  0, 4'd0,  1'b0, 4'b0100};
    ph[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 4,  0, 4'd0,  1'b0, 4'b1000};
    ph[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 4,  0, 4'd0,  1'b0, 4'b0001};
    ph[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 4,  0, 4'd0,  1'b0, 4'b0010};
    ph[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 26, 1, 4'd0,  1'b1, 4'b0001}; // stable hold
    ph[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 4,  0, 4'd0,  1'b1, 4'b0001}; // release bounce
    ph[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 12, 0, 4'd0,  1'b1, 4'b0001};
    ph[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 13, 0, 4'd0,  1'b1, 4'b0001}; // stable release
    ph[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1,  0, 4'd0,  1'b0, 4'b0010};
    ph[17] = '{1'b1, 1'b1, 4'h5, 1'b0, 2'd0, 2'd0, 40, 0, 4'd0,  1'b0, 4'b0100}; // ghost 0101

    for (int i = 0; i < 16; i++) begin
      exp_rot[i] = 4'b0001 << (((i + 1) / 4) % 4);
    end

    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("rotate_%0d", i), row_sweep, exp_rot[i]);
    end
    chk_int("rotate_no_strobe", strobes, 0);

    for (int p = 0; p < NPH; p++) begin
      raw_on  = ph[p].raw_on;
      raw_col = ph[p].raw_col;
      kp_on   = ph[p].kp_on;
      kp_row  = ph[p].kp_row;
      kp_col  = ph[p].kp_col;
      strobes = 0;
      if (ph[p].do_rst) begin
        apply_reset();
      end else begin
        drive_cols();
      end
      repeat (ph[p].cycles) cyc();
      chk_int($sformatf("ph%0d_strobes", p), strobes, ph[p].exp_strobes);
      if (ph[p].exp_strobes > 0) begin
        chk($sformatf("ph%0d_strobe_code", p), last_code, ph[p].exp_code);
      end
      chk($sformatf("ph%0d_code", p), key_code, ph[p].exp_code);
      chk($sformatf("ph%0d_held", p), {3'b000, key_held}, {3'b000, ph[p].exp_held});
      chk($sformatf("ph%0d_row", p), row_sweep, ph[p].exp_row);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
